// File: rtl/synchronizer_filter.sv
// Multi-channel level synchronizer with per-channel persistence filter.
// Rise/fall pulses only when SYNCHRONIZER_FILTER_EDGE_EN is defined.
module synchronizer_filter #(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 1,
  parameter logic [WIDTH-1:0] RESET_STATE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  localparam int CNT_W =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_STATE;
      end
    end else begin
      sync_q[0] <= data_i;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync = sync_q[STAGES-1];

  // Counter restarts whenever the synced value agrees with data_o.
  always_comb begin
    data_d = data_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != data_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          data_d[i] = sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_STATE;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      data_q <= data_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_o = data_q;

`ifdef SYNCHRONIZER_FILTER_EDGE_EN
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  assign rise_d = data_d & ~data_q;
  assign fall_d = ~data_d & data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

// File: tb/tb_synchronizer_filter.sv
// Directed bench for synchronizer_filter: three configurations,
// table-driven filter/glitch sequence plus reset and latency corners.
module tb_synchronizer_filter;

`ifdef SYNCHRONIZER_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [0:0] a_i = '0;
  logic [0:0] a_o, a_r, a_f;
  logic [3:0] b_i = '0;
  logic [3:0] b_o, b_r, b_f;
  logic [3:0] c_i = '0;
  logic [3:0] c_o, c_r, c_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  synchronizer_filter #(
    .WIDTH(1), .STAGES(2), .FILTER_CYCLES(1),
    .RESET_STATE(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .data_i(a_i),
    .data_o(a_o), .rise_o(a_r), .fall_o(a_f)
  );

  synchronizer_filter #(
    .WIDTH(4), .STAGES(3), .FILTER_CYCLES(4),
    .RESET_STATE(4'b0000)
  ) dut_b (
    .clk(clk), .reset(reset), .data_i(b_i),
    .data_o(b_o), .rise_o(b_r), .fall_o(b_f)
  );

  synchronizer_filter #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(2),
    .RESET_STATE(4'b1010)
  ) dut_c (
    .clk(clk), .reset(reset), .data_i(c_i),
    .data_o(c_o), .rise_o(c_r), .fall_o(c_f)
  );

  typedef struct {
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [29];

  function automatic logic [3:0] ep(input logic [3:0] x);
    return EDGE ? x : 4'b0000;
  endfunction

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_row(input int i, input logic [3:0] din,
                         input logic [3:0] dout,
                         input logic [3:0] r,
                         input logic [3:0] f);
    tbl[i].din = din;
    tbl[i].dout = dout;
    tbl[i].rise = r;
    tbl[i].fall = f;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_row(i, 4'b0001, 4'b0000, 0, 0);
    for (int i = 3; i < 9; i++) set_row(i, 4'b0000, 4'b0000, 0, 0);
    for (int i = 9; i < 15; i++) set_row(i, 4'b0101, 4'b0000, 0, 0);
    set_row(15, 4'b0101, 4'b0101, 4'b0101, 0);
    set_row(16, 4'b0101, 4'b0101, 0, 0);
    for (int i = 17; i < 21; i++) set_row(i, 4'b0111, 4'b0101, 0, 0);
    set_row(21, 4'b0101, 4'b0101, 0, 0);
    set_row(22, 4'b0101, 4'b0101, 0, 0);
    set_row(23, 4'b0101, 4'b0111, 4'b0010, 0);
    for (int i = 24; i < 27; i++) set_row(i, 4'b0101, 4'b0111, 0, 0);
    set_row(27, 4'b0101, 4'b0101, 0, 4'b0010);
    set_row(28, 4'b0101, 4'b0101, 0, 0);

    // reset state of all three instances
    a_i = '0; b_i = '0; c_i = 4'b0000;
    reset = 1'b1;
    step();
    chk("rst_a_data", {3'b0, a_o}, 4'b0000);
    chk("rst_b_data", b_o, 4'b0000);
    chk("rst_c_data", c_o, 4'b1010);
    chk("rst_c_rise", c_r, 4'b0000);
    chk("rst_c_fall", c_f, 4'b0000);
    step();
    reset = 1'b0;

    // plain 2-flop synchronizer latency and rise pulse
    a_i = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      chk($sformatf("a_data_e%0d", e), {3'b0, a_o},
          (e >= 2) ? 4'b0001 : 4'b0000);
      chk($sformatf("a_rise_e%0d", e), {3'b0, a_r},
          ep((e == 2) ? 4'b0001 : 4'b0000));
      chk($sformatf("a_fall_e%0d", e), {3'b0, a_f}, 4'b0000);
    end

    // filtered 4-channel sequence: glitch, accept, pulse, release
    do_reset();
    for (int i = 0; i < 29; i++) begin
      b_i = tbl[i].din;
      step();
      chk($sformatf("b_data_r%0d", i), b_o, tbl[i].dout);
      chk($sformatf("b_rise_r%0d", i), b_r, ep(tbl[i].rise));
      chk($sformatf("b_fall_r%0d", i), b_f, ep(tbl[i].fall));
    end

    // reset while counters are mid-count
    do_reset();
    c_i = 4'b0101;
    for (int e = 0; e < 3; e++) begin
      step();
      chk($sformatf("c_pre_e%0d", e), c_o, 4'b1010);
    end
    reset = 1'b1;
    step();
    chk("c_midrst_data", c_o, 4'b1010);
    chk("c_midrst_rise", c_r, 4'b0000);
    chk("c_midrst_fall", c_f, 4'b0000);
    step();
    reset = 1'b0;

    // after release, ch1/ch3 fall at edge STAGES+F-1 = 3
    c_i = 4'b0000;
    for (int e = 0; e < 5; e++) begin
      step();
      chk($sformatf("c_fall_data_e%0d", e), c_o,
          (e >= 3) ? 4'b0000 : 4'b1010);
      chk($sformatf("c_fall_f_e%0d", e), c_f,
          ep((e == 3) ? 4'b1010 : 4'b0000));
      chk($sformatf("c_fall_r_e%0d", e), c_r, 4'b0000);
    end

    // simultaneous rise on ch0 and fall on ch1
    do_reset();
    c_i = 4'b1001;
    for (int e = 0; e < 5; e++) begin
      step();
      chk($sformatf("c_sim_data_e%0d", e), c_o,
          (e >= 3) ? 4'b1001 : 4'b1010);
      chk($sformatf("c_sim_r_e%0d", e), c_r,
          ep((e == 3) ? 4'b0001 : 4'b0000));
      chk($sformatf("c_sim_f_e%0d", e), c_f,
          ep((e == 3) ? 4'b0010 : 4'b0000));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
